// File: rtl/sdrc_req_arbiter_if.sv
// Request/write/read channel of the SDRAM controller application port.
// A requester drives it as master; the core side consumes it as slave.
interface sdrc_req_arbiter_if #(
  parameter int APP_AW = 26,
  parameter int bl     = 9,
  parameter int dw     = 32
);
  logic              req;
  logic [APP_AW-1:0] req_addr;
  logic [bl-1:0]     req_len;
  logic              req_wr_n;
  logic              req_ack;
  logic [dw-1:0]     wr_data;
  logic [dw/8-1:0]   wr_en_n;
  logic              wr_next;
  logic [dw-1:0]     rd_data;
  logic              rd_valid;
  logic              last_rd;

  modport master (
    output req, req_addr, req_len, req_wr_n, wr_data, wr_en_n,
    input  req_ack, wr_next, rd_data, rd_valid, last_rd
  );

  modport slave (
    input  req, req_addr, req_len, req_wr_n, wr_data, wr_en_n,
    output req_ack, wr_next, rd_data, rd_valid, last_rd
  );
endinterface

// File: rtl/sdrc_req_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller application port between
// two requesters; a grant is held until the granted burst has completed.
module sdrc_req_arbiter #(
  parameter int APP_AW = 26,
  parameter int bl     = 9,
  parameter int dw     = 32
) (
  input  logic               sdram_clk,
  input  logic               sdram_resetn,
  input  logic               sdr_init_done,
  sdrc_req_arbiter_if.slave  r0,
  sdrc_req_arbiter_if.slave  r1,
  sdrc_req_arbiter_if.master app,
  output logic               arb_busy
);
  // state | meaning
  // IDLE  | no grant; arbitrate once sdr_init_done is high
  // REQ   | granted request presented to the core, waiting for app_req_ack
  // WR    | write burst, counter steps down on each app_wr_next_req
  // RD    | read burst, ends on app_rd_valid & app_last_rd
  typedef enum logic [1:0] {IDLE, REQ, WR, RD} state_t;

  state_t            state, state_d;
  logic              grant, grant_d;
  logic              last_grant, last_grant_d;
  logic [bl-1:0]     cnt, cnt_d;
  logic              sel_req;
  logic              sel_wr_n;
  logic [APP_AW-1:0] sel_addr;
  logic [bl-1:0]     sel_len;
  logic [dw-1:0]     sel_wr_data;
  logic [dw/8-1:0]   sel_wr_en_n;

  assign sel_req     = grant ? r1.req      : r0.req;
  assign sel_wr_n    = grant ? r1.req_wr_n : r0.req_wr_n;
  assign sel_addr    = grant ? r1.req_addr : r0.req_addr;
  assign sel_len     = grant ? r1.req_len  : r0.req_len;
  assign sel_wr_data = grant ? r1.wr_data  : r0.wr_data;
  assign sel_wr_en_n = grant ? r1.wr_en_n  : r0.wr_en_n;

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
      cnt        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state;
    grant_d      = grant;
    last_grant_d = last_grant;
    cnt_d        = cnt;
    app.req      = 1'b0;
    app.req_addr = '0;
    app.req_len  = '0;
    app.req_wr_n = 1'b0;
    app.wr_data  = '0;
    app.wr_en_n  = '1;
    r0.req_ack   = 1'b0;
    r1.req_ack   = 1'b0;
    r0.wr_next   = 1'b0;
    r1.wr_next   = 1'b0;
    r0.rd_data   = '0;
    r1.rd_data   = '0;
    r0.rd_valid  = 1'b0;
    r1.rd_valid  = 1'b0;
    r0.last_rd   = 1'b0;
    r1.last_rd   = 1'b0;
    case (state)
      IDLE: begin
        // a contested grant goes to the port that did not win last time
        if (sdr_init_done && (r0.req || r1.req)) begin
          grant_d = (r0.req && r1.req) ? ~last_grant : r1.req;
          state_d = REQ;
        end
      end
      REQ: begin
        app.req      = 1'b1;
        app.req_addr = sel_addr;
        app.req_len  = sel_len;
        app.req_wr_n = sel_wr_n;
        if (app.req_ack) begin
          r0.req_ack = ~grant;
          r1.req_ack = grant;
          cnt_d      = sel_len;
          state_d    = sel_wr_n ? RD : WR;
        end
      end
      WR: begin
        app.wr_data = sel_wr_data;
        app.wr_en_n = sel_wr_en_n;
        r0.wr_next  = app.wr_next & ~grant;
        r1.wr_next  = app.wr_next & grant;
        // len 0 wraps to the full 2^bl words before reaching 1
        if (app.wr_next) begin
          cnt_d = cnt - 1'b1;
          if (cnt == bl'(1)) begin
            state_d      = IDLE;
            last_grant_d = grant;
          end
        end
      end
      RD: begin
        r0.rd_data  = app.rd_data;
        r1.rd_data  = app.rd_data;
        r0.rd_valid = app.rd_valid & ~grant;
        r1.rd_valid = app.rd_valid & grant;
        r0.last_rd  = app.rd_valid & app.last_rd & ~grant;
        r1.last_rd  = app.rd_valid & app.last_rd & grant;
        if (app.rd_valid && app.last_rd) begin
          state_d      = IDLE;
          last_grant_d = grant;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign arb_busy = (state != IDLE);

  // the granted requester must hold its request until the core accepts it
  a_req_held: assert property (@(posedge sdram_clk) disable iff (!sdram_resetn)
                               (state == REQ) |-> sel_req);
endmodule

// File: tb/tb_sdrc_req_arbiter.sv
// Scoreboard bench for sdrc_req_arbiter: stimulus queues expected events,
// a negedge monitor pops and compares each event the DUT presents.
`timescale 1ns/1ps
module tb_sdrc_req_arbiter;
  localparam int AW = 26;
  localparam int BL = 9;
  localparam int DW = 32;
  localparam int K_GRANT  = 0;
  localparam int K_ACK    = 1;
  localparam int K_WNEXT  = 2;
  localparam int K_RVALID = 3;
  localparam int K_STRAY  = 4;

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] data;
    logic [31:0] aux;
    int          cyc;
  } ev_t;

  logic sdram_clk = 1'b0;
  logic sdram_resetn = 1'b0;
  logic sdr_init_done = 1'b0;
  logic arb_busy;

  sdrc_req_arbiter_if #(.APP_AW(AW), .bl(BL), .dw(DW)) r0 ();
  sdrc_req_arbiter_if #(.APP_AW(AW), .bl(BL), .dw(DW)) r1 ();
  sdrc_req_arbiter_if #(.APP_AW(AW), .bl(BL), .dw(DW)) app ();

  sdrc_req_arbiter #(.APP_AW(AW), .bl(BL), .dw(DW)) dut (
    .sdram_clk     (sdram_clk),
    .sdram_resetn  (sdram_resetn),
    .sdr_init_done (sdr_init_done),
    .r0            (r0),
    .r1            (r1),
    .app           (app),
    .arb_busy      (arb_busy)
  );

  always #5 sdram_clk = ~sdram_clk;

  ev_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic prev_req = 1'b0;

  always @(posedge sdram_clk) cyc++;

  function automatic void observe(int kind, int port, logic [31:0] data, logic [31:0] aux);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d port=%0d data=%h aux=%h cyc=%0d, required no event",
               kind, port, data, aux, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.port != port || e.data !== data || e.aux !== aux ||
        (e.cyc >= 0 && e.cyc != cyc)) begin
      bad++;
      $display("FAIL %s: got kind=%0d port=%0d data=%h aux=%h cyc=%0d, required kind=%0d port=%0d data=%h aux=%h cyc=%0d",
               e.name, kind, port, data, aux, cyc, e.kind, e.port, e.data, e.aux, e.cyc);
    end
  endfunction

  function automatic int pidx(logic a, logic b);
    return (a && b) ? 2 : (b ? 1 : 0);
  endfunction

  always @(negedge sdram_clk) begin
    if (sdram_resetn) begin
      if (app.req && !prev_req)
        observe(K_GRANT, 0, 32'(app.req_addr), 32'({app.req_wr_n, app.req_len}));
      if (r0.req_ack || r1.req_ack)
        observe(K_ACK, pidx(r0.req_ack, r1.req_ack), 32'h0, 32'h0);
      if (r0.wr_next || r1.wr_next)
        observe(K_WNEXT, pidx(r0.wr_next, r1.wr_next), app.wr_data, 32'(app.wr_en_n));
      if (r0.rd_valid || r1.rd_valid)
        observe(K_RVALID, pidx(r0.rd_valid, r1.rd_valid), r1.rd_valid ? r1.rd_data : r0.rd_data,
                {30'b0, r1.last_rd, r0.last_rd});
      else if (r0.last_rd || r1.last_rd)
        observe(K_STRAY, 0, 32'h0, {30'b0, r1.last_rd, r0.last_rd});
    end
    prev_req = app.req;
  end

  task automatic tick();
    @(posedge sdram_clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp_v);
    end
  endtask

  task automatic push(string name, int kind, int port, logic [31:0] data, logic [31:0] aux, int c);
    ev_t e;
    e.name = name; e.kind = kind; e.port = port; e.data = data; e.aux = aux; e.cyc = c;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] wdat(int port, int k);
    return 32'hC0DE_0000 ^ 32'(port * 65536) ^ 32'(k * 4099);
  endfunction

  function automatic logic [3:0] wen(int k);
    return 4'(k * 3 + 1);
  endfunction

  function automatic logic [31:0] rdat(int k);
    return 32'h5EED_0000 + 32'(k * 273);
  endfunction

  task automatic post(int port, logic [AW-1:0] addr, logic [BL-1:0] len, logic wr_n);
    if (port == 0) begin
      r0.req_addr = addr; r0.req_len = len; r0.req_wr_n = wr_n; r0.req = 1'b1;
    end else begin
      r1.req_addr = addr; r1.req_len = len; r1.req_wr_n = wr_n; r1.req = 1'b1;
    end
  endtask

  task automatic wait_grant(int port, output bit got);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (app.req) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL grant_timeout port%0d: got app_req=0, required app_req=1 within 200 cycles", port);
    end
  endtask

  task automatic set_wdata(int port, int k);
    r0.wr_data = (port == 0) ? wdat(0, k) : ~wdat(0, k);
    r1.wr_data = (port == 1) ? wdat(1, k) : ~wdat(1, k);
    r0.wr_en_n = (port == 0) ? wen(k) : ~wen(k);
    r1.wr_en_n = (port == 1) ? wen(k) : ~wen(k);
  endtask

  // Acts as the core for one burst of the port expected to win.
  task automatic serve(int port, int exp_cyc, bit gap);
    logic [AW-1:0] a;
    logic [BL-1:0] l;
    logic          wn;
    int            n;
    bit            got;
    a  = (port == 0) ? r0.req_addr : r1.req_addr;
    l  = (port == 0) ? r0.req_len  : r1.req_len;
    wn = (port == 0) ? r0.req_wr_n : r1.req_wr_n;
    n  = (l == 0) ? 512 : int'(l);
    push("grant", K_GRANT, 0, 32'(a), 32'({wn, l}), exp_cyc);
    wait_grant(port, got);
    if (!got) return;
    push("req_ack", K_ACK, port, 32'h0, 32'h0, -1);
    app.req_ack = 1'b1;
    tick();
    app.req_ack = 1'b0;
    if (port == 0) r0.req = 1'b0; else r1.req = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!wn) begin
        set_wdata(port, k);
        app.wr_next = 1'b1;
        push("wr_next", K_WNEXT, port, wdat(port, k), 32'(wen(k)), -1);
        tick();
        app.wr_next = 1'b0;
      end else begin
        app.rd_data  = rdat(k);
        app.rd_valid = 1'b1;
        app.last_rd  = (k == n - 1);
        push("rd_valid", K_RVALID, port, rdat(k), (k == n - 1) ? ((port == 1) ? 32'h2 : 32'h1) : 32'h0, -1);
        tick();
        app.rd_valid = 1'b0;
        app.last_rd  = 1'b0;
      end
      if (gap && k < n - 1 && (k % 2) == 0) tick();
    end
    chk("idle_after_burst", 32'(arb_busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    bit  got;
    r0.req = 0; r0.req_addr = '0; r0.req_len = '0; r0.req_wr_n = 0; r0.wr_data = 32'h1111_1111; r0.wr_en_n = 4'h3;
    r1.req = 0; r1.req_addr = '0; r1.req_len = '0; r1.req_wr_n = 0; r1.wr_data = 32'h2222_2222; r1.wr_en_n = 4'h6;
    app.req_ack = 1; app.wr_next = 1; app.rd_data = 32'hDEAD_BEEF; app.rd_valid = 1; app.last_rd = 1;
    #3;
    chk("rst_app_req",     32'(app.req),      32'h0);
    chk("rst_app_addr",    32'(app.req_addr), 32'h0);
    chk("rst_app_wr_en_n", 32'(app.wr_en_n),  32'hF);
    chk("rst_app_wr_data", app.wr_data,       32'h0);
    chk("rst_r0_rd_data",  r0.rd_data,        32'h0);
    chk("rst_r1_outs", {28'b0, r1.req_ack, r1.wr_next, r1.rd_valid, r1.last_rd}, 32'h0);
    chk("rst_r0_outs", {28'b0, r0.req_ack, r0.wr_next, r0.rd_valid, r0.last_rd}, 32'h0);
    chk("rst_busy",        32'(arb_busy),     32'h0);
    app.req_ack = 0; app.wr_next = 0; app.rd_valid = 0; app.last_rd = 0;
    tick(); tick();
    sdram_resetn = 1'b1;
    sdr_init_done = 1'b1;
    tick();

    // 1: r0 write, 4 words
    c = cyc;
    post(0, 26'h100, 9'd4, 1'b0);
    serve(0, c + 1, 1'b1);
    tick();

    // 2: r1 read, 3 words
    c = cyc;
    post(1, 26'h200, 9'd3, 1'b1);
    serve(1, c + 1, 1'b1);
    tick();

    // 3: simultaneous requests after reset
    sdram_resetn = 1'b0;
    tick();
    sdram_resetn = 1'b1;
    c = cyc;
    post(0, 26'h300, 9'd2, 1'b0);
    post(1, 26'h340, 9'd2, 1'b0);
    serve(0, c + 1, 1'b0);
    serve(1, -1, 1'b0);
    tick();
    post(0, 26'h380, 9'd1, 1'b1);
    post(1, 26'h3C0, 9'd1, 1'b1);
    serve(0, -1, 1'b0);
    serve(1, -1, 1'b0);
    tick();

    // 4: no grant while init is low; stray read data in IDLE is dropped
    sdr_init_done = 1'b0;
    post(0, 26'h0F0, 9'd1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      app.rd_valid = (i == 5);
      app.last_rd  = (i == 5);
      tick();
      chk("no_grant_init_low", 32'(app.req), 32'h0);
      chk("stray_rd_valid", {30'b0, r1.rd_valid, r0.rd_valid}, 32'h0);
    end
    app.rd_valid = 1'b0;
    app.last_rd  = 1'b0;
    sdr_init_done = 1'b1;
    c = cyc;
    serve(0, c + 1, 1'b0);
    tick();

    // 5: len 0 is a full 512-word burst
    post(0, 26'h400, 9'd0, 1'b0);
    serve(0, -1, 1'b0);
    tick();

    // 6: reset during the second word of an 8-word write
    post(0, 26'h0A0, 9'd8, 1'b0);
    push("grant", K_GRANT, 0, 32'h0A0, 32'({1'b0, 9'd8}), -1);
    wait_grant(0, got);
    if (got) begin
      push("req_ack", K_ACK, 0, 32'h0, 32'h0, -1);
      app.req_ack = 1'b1;
      tick();
      app.req_ack = 1'b0;
      r0.req = 1'b0;
      set_wdata(0, 0);
      app.wr_next = 1'b1;
      push("wr_next", K_WNEXT, 0, wdat(0, 0), 32'(wen(0)), -1);
      tick();
      set_wdata(0, 1);
      #2;
      sdram_resetn = 1'b0;
      #1;
      chk("rst_mid_wr_next", {30'b0, r1.wr_next, r0.wr_next}, 32'h0);
      chk("rst_mid_wr_en_n", 32'(app.wr_en_n), 32'hF);
      chk("rst_mid_wr_data", app.wr_data, 32'h0);
      chk("rst_mid_busy",    32'(arb_busy), 32'h0);
      chk("rst_mid_app_req", 32'(app.req), 32'h0);
    end
    app.wr_next = 1'b0;
    post(1, 26'h1B0, 9'd2, 1'b1);
    tick(); tick();
    sdram_resetn = 1'b1;
    c = cyc;
    tick();
    post(0, 26'h0C0, 9'd1, 1'b0);
    serve(1, c + 1, 1'b0);
    serve(0, -1, 1'b0);

    repeat (5) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdrc_req_arbiter.md
Name: sdrc_req_arbiter

Overview:
Two-port arbiter that shares the single application request interface of the SDRAM controller core between two requesters, for example two Wishbone bridges.
- Grants one requester at a time using round-robin.
- Forwards that requester's request to the core and routes the core's write-data handshake and read-data return to it.
- Holds the grant until the whole burst completes.
- Sits between the bridges and the core, in the sdram_clk domain.

Parameters:
APP_AW, 26, application address width
bl, 9, burst length width
dw, 32, application data width

Ports:
sdram_clk  in  1  clock
sdram_resetn  in  1  asynchronous active-low reset
sdr_init_done  in  1  core initialisation complete; no grant is issued while low
rN_req  in  1  request from port N (N=0,1); held until rN_req_ack
rN_req_addr  in  APP_AW  request address
rN_req_len  in  bl  burst length in dw words
rN_req_wr_n  in  1  0 = write, 1 = read
rN_req_ack  out  1  request accepted by core
rN_wr_data  in  dw  write data
rN_wr_en_n  in  dw/8  active-low byte enables
rN_wr_next  out  1  core consumed current write word
rN_rd_data  out  dw  read data
rN_rd_valid  out  1  read data valid
rN_last_rd  out  1  last read word of burst
app_req  out  1  request to core
app_req_addr  out  APP_AW  request address to core
app_req_len  out  bl  burst length to core
app_req_wr_n  out  1  direction to core
app_req_ack  in  1  core accepted request
app_wr_data  out  dw  write data to core
app_wr_en_n  out  dw/8  byte enables to core
app_wr_next_req  in  1  core wants next write word
app_rd_data  in  dw  read data from core
app_rd_valid  in  1  read data valid from core
app_last_rd  in  1  last read of burst
arb_busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - state IDLE, grant=0, last_grant=1 (port 0 has first priority), burst counter 0.
  - All outputs 0 except app_wr_en_n and rN_wr_en-derived enables, which are all-ones.
- State IDLE:
  - If sdr_init_done=1 and any rN_req=1, the winner is latched into grant and state moves to REQ on the next edge.
  - With one request, that port wins.
  - With both requesting, the port != last_grant wins.
- State REQ:
  - app_req=1.
  - app_req_addr, app_req_len and app_req_wr_n are a combinational mux of the granted port's inputs.
  - Latency is 1 cycle from rN_req rising in IDLE to app_req.
  - On app_req_ack=1, rN_req_ack of the granted port is asserted in the same cycle (combinational pass-through, single-cycle pulse).
  - On that ack, the burst counter loads the granted len and state goes to WR (wr_n=0) or RD (wr_n=1).
- State WR:
  - app_wr_data and app_wr_en_n come from the granted port; the other port's rN_wr_next=0.
  - Granted rN_wr_next = app_wr_next_req.
  - The counter decrements on each app_wr_next_req.
  - When app_wr_next_req=1 with counter==1, go to IDLE and set last_grant=grant.
  - len=0 is treated as 2^bl words: the counter wraps 0→511 and the burst ends at 1.
- State RD:
  - rN_rd_data = app_rd_data on both ports.
  - Granted rN_rd_valid = app_rd_valid and rN_last_rd = app_last_rd&app_rd_valid; the other port sees 0.
  - app_rd_valid&app_last_rd → IDLE, last_grant=grant.
- Outside WR: app_wr_en_n all-ones and both rN_wr_next=0.
- Outside RD: both rN_rd_valid=0. A stray app_rd_valid is dropped.
- Serialisation and timing:
  - Only one outstanding request exists; a new request is never forwarded while a burst is active.
  - At least one IDLE cycle separates consecutive bursts.
- Requester deassert before ack: the arbiter keeps app_req asserted in REQ until ack. Requesters must not drop rN_req; this is checked by an assertion.
- sdr_init_done dropping mid-burst: the current burst completes normally; no new grant is issued until it returns high.
- Asynchronous reset mid-burst: everything returns to reset values immediately; the partial burst is abandoned.

Test Plan:
1. Reset, sdr_init_done=1, r0 write addr=0x100 len=4 → app_req 1 cycle after r0_req; r0_req_ack pulses with app_req_ack; 4 r0_wr_next pulses; return to IDLE; r1 outputs stay 0 throughout.
2. r1 read len=3, core returns 3 rd_valid with app_last_rd on the 3rd → r1_rd_valid ×3, r1_last_rd on the 3rd; r0_rd_valid stays 0.
3. r0 and r1 request in the same cycle after reset → r0 granted first; r1 granted after r0's burst ends; then with both requesting again, r0 is granted.
4. sdr_init_done=0 with r0_req=1 for 20 cycles → app_req stays 0; app_req appears 1 cycle after sdr_init_done rises.
5. r0 write len=0 → 512 r0_wr_next pulses before IDLE.
6. Assert sdram_resetn low during the 2nd word of a len=8 write → all outputs at reset values immediately; after release, r1 pending request is granted before r0.
